// File: rtl/axi_sram_lat_if.sv
// axi_sram_lat_if: AXI-lite style read/write bus between a master and the SRAM slave
interface axi_sram_lat_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axi_sram_lat.sv
// axi_sram_lat: word-addressed SRAM behind AXI-lite style channels with programmable read/write latency
module axi_sram_lat #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int DEPTH         = 1024,
   parameter int READ_LATENCY  = 1,
   parameter int WRITE_LATENCY = 1
) (
   input logic           aclk,
   input logic           areset,
   axi_sram_lat_if.slave bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int SH = $clog2(NB);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   r_state_t              r_state, r_nstate;
   w_state_t              w_state, w_nstate;
   logic [3:0]            r_cnt, r_ncnt, w_cnt, w_ncnt;
   logic                  rdy_q;
   logic [ADDR_WIDTH-1:0] ar_q, aw_q;
   logic [DATA_WIDTH-1:0] wd_q;
   logic [NB-1:0]         ws_q;
   logic                  aw_got, w_got;
   logic                  ar_hs, aw_hs, w_hs, commit, r_load;
   logic [ADDR_WIDTH-1:0] r_addr, r_idx, w_addr, w_idx;
   logic [DATA_WIDTH-1:0] w_data;
   logic [NB-1:0]         w_strb;
   logic                  r_ok, w_ok;
   assign ar_hs  = bus.arvalid && bus.arready;
   assign aw_hs  = bus.awvalid && bus.awready;
   assign w_hs   = bus.wvalid && bus.wready;
   assign commit = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
   assign r_load = (r_state != R_RESP) && (r_nstate == R_RESP);
   assign r_addr = (r_state == R_IDLE) ? bus.araddr : ar_q;
   assign w_addr = aw_got ? aw_q : bus.awaddr;
   assign w_data = w_got ? wd_q : bus.wdata;
   assign w_strb = w_got ? ws_q : bus.wstrb;
   assign r_idx  = r_addr >> SH;
   assign w_idx  = w_addr >> SH;
   assign r_ok   = r_idx < ADDR_WIDTH'(DEPTH);
   assign w_ok   = w_idx < ADDR_WIDTH'(DEPTH);
   // state and latency counters of both channel FSMs
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
         r_cnt   <= '0;
         w_cnt   <= '0;
      end else begin
         r_state <= r_nstate;
         w_state <= w_nstate;
         r_cnt   <= r_ncnt;
         w_cnt   <= w_ncnt;
      end
   end
   // read FSM: accept AR, count down the latency, hold the response until rready
   always_comb begin
      r_nstate = r_state;
      r_ncnt   = r_cnt;
      case (r_state)
         R_IDLE: if (ar_hs) begin
            r_nstate = (READ_LATENCY == 1) ? R_RESP : R_WAIT;
            r_ncnt   = 4'(READ_LATENCY - 1);
         end
         R_WAIT: begin
            r_ncnt   = r_cnt - 4'd1;
            r_nstate = (r_cnt == 4'd1) ? R_RESP : R_WAIT;
         end
         R_RESP: r_nstate = bus.rready ? R_IDLE : R_RESP;
         default: r_nstate = R_IDLE;
      endcase
   end
   // write FSM: commit once AW and W are both in hand, count down, hold the response until bready
   always_comb begin
      w_nstate = w_state;
      w_ncnt   = w_cnt;
      case (w_state)
         W_IDLE: if (commit) begin
            w_nstate = (WRITE_LATENCY == 1) ? W_RESP : W_WAIT;
            w_ncnt   = 4'(WRITE_LATENCY - 1);
         end
         W_WAIT: begin
            w_ncnt   = w_cnt - 4'd1;
            w_nstate = (w_cnt == 4'd1) ? W_RESP : W_WAIT;
         end
         W_RESP: w_nstate = bus.bready ? W_IDLE : W_RESP;
         default: w_nstate = W_IDLE;
      endcase
   end
   // handshake outputs; readies stay low until the first edge after reset
   always_comb begin
      bus.arready = rdy_q && (r_state == R_IDLE);
      bus.rvalid  = r_state == R_RESP;
      bus.awready = rdy_q && (w_state == W_IDLE) && !aw_got;
      bus.wready  = rdy_q && (w_state == W_IDLE) && !w_got;
      bus.bvalid  = w_state == W_RESP;
   end
   // captured addresses/data, channel flags and registered responses
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         rdy_q     <= 1'b0;
         ar_q      <= '0;
         aw_q      <= '0;
         wd_q      <= '0;
         ws_q      <= '0;
         aw_got    <= 1'b0;
         w_got     <= 1'b0;
         bus.rdata <= '0;
         bus.rresp <= 2'b00;
         bus.bresp <= 2'b00;
      end else begin
         rdy_q <= 1'b1;
         if (ar_hs) ar_q <= bus.araddr;
         if (aw_hs) aw_q <= bus.awaddr;
         if (w_hs) begin
            wd_q <= bus.wdata;
            ws_q <= bus.wstrb;
         end
         aw_got <= commit ? 1'b0 : (aw_got || aw_hs);
         w_got  <= commit ? 1'b0 : (w_got || w_hs);
         if (r_load) begin
            bus.rdata <= r_ok ? mem[r_idx[IW-1:0]] : '0;
            bus.rresp <= r_ok ? 2'b00 : 2'b10;
         end
         if (commit) bus.bresp <= w_ok ? 2'b00 : 2'b10;
      end
   end
   // byte-masked array write at commit; contents are never reset
   always_ff @(posedge aclk) begin
      for (int i = 0; i < NB; i++)
         if (commit && w_ok && w_strb[i]) mem[w_idx[IW-1:0]][8*i +: 8] <= w_data[8*i +: 8];
   end
endmodule

// File: tb/tb_axi_sram_lat.sv
// tb_axi_sram_lat: directed plus randomized checks of axi_sram_lat against a word-array reference model
module tb_axi_sram_lat;
   localparam int RL = 3;
   localparam int WL = 2;
   logic        aclk;
   logic        areset;
   int          tests;
   int          fails;
   logic [31:0] model [1024];
   axi_sram_lat_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
   axi_sram_lat #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024),
      .READ_LATENCY(RL), .WRITE_LATENCY(WL)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .bus(bus)
   );
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [33:0] exp_read(input logic [31:0] a);
      logic [31:0] i;
      i = a >> 2;
      if (i >= 32'd1024) return {2'b10, 32'h0};
      return {2'b00, model[i[9:0]]};
   endfunction
   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] i;
      i = a >> 2;
      if (i < 32'd1024)
         for (int b = 0; b < 4; b++)
            if (s[b]) model[i[9:0]][8*b +: 8] = d[8*b +: 8];
   endtask
   task automatic send_aw(input logic [31:0] a);
      int n;
      bus.awaddr  = a;
      bus.awvalid = 1'b1;
      n = 0;
      while (!bus.awready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("aw_wait", 64'(n < 50), 1);
      @(negedge aclk);
      bus.awvalid = 1'b0;
   endtask
   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n;
      bus.wdata  = d;
      bus.wstrb  = s;
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("w_wait", 64'(n < 50), 1);
      @(negedge aclk);
      bus.wvalid = 1'b0;
   endtask
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
      int n;
      logic [1:0] er;
      er = ((a >> 2) >= 32'd1024) ? 2'b10 : 2'b00;
      if (lead == 0) begin
         bus.awaddr  = a;
         bus.wdata   = d;
         bus.wstrb   = s;
         bus.awvalid = 1'b1;
         bus.wvalid  = 1'b1;
         n = 0;
         while (!(bus.awready && bus.wready) && n < 50) begin
            @(negedge aclk);
            n++;
         end
         chk("aww_wait", 64'(n < 50), 1);
         @(negedge aclk);
         bus.awvalid = 1'b0;
         bus.wvalid  = 1'b0;
      end else if (lead > 0) begin
         send_w(d, s);
         chk("w_first_wready", bus.wready, 0);
         chk("w_first_awready", bus.awready, 1);
         repeat (lead - 1) begin
            @(negedge aclk);
            chk("w_first_no_b", bus.bvalid, 0);
         end
         send_aw(a);
      end else begin
         send_aw(a);
         chk("aw_first_awready", bus.awready, 0);
         chk("aw_first_wready", bus.wready, 1);
         repeat (-lead - 1) begin
            @(negedge aclk);
            chk("aw_first_no_b", bus.bvalid, 0);
         end
         send_w(d, s);
      end
      model_write(a, d, s);
      n = 1;
      while (!bus.bvalid && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("b_latency", n, WL);
      chk("bresp", bus.bresp, er);
      bus.bready = 1'b1;
      @(negedge aclk);
      bus.bready = 1'b0;
      chk("b_drop", bus.bvalid, 0);
   endtask
   task automatic do_read(input logic [31:0] a, input int hold);
      int n;
      logic [33:0] e;
      e = exp_read(a);
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      n = 0;
      while (!bus.arready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("ar_wait", 64'(n < 50), 1);
      @(negedge aclk);
      bus.arvalid = 1'b0;
      n = 1;
      while (!bus.rvalid && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("r_latency", n, RL);
      chk("rdata", bus.rdata, e[31:0]);
      chk("rresp", bus.rresp, e[33:32]);
      repeat (hold) begin
         @(negedge aclk);
         chk("r_hold_valid", bus.rvalid, 1);
         chk("r_hold_data", bus.rdata, e[31:0]);
         chk("r_hold_arready", bus.arready, 0);
      end
      bus.rready = 1'b1;
      @(negedge aclk);
      bus.rready = 1'b0;
      chk("r_drop", bus.rvalid, 0);
      chk("r_arready_back", bus.arready, 1);
   endtask
   initial begin
      logic [31:0] a, d, old;
      logic [3:0]  s;
      int          n;
      tests = 0;
      fails = 0;
      areset = 1'b0;
      bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 1'b0; bus.bready = 1'b0;
      repeat (3) @(negedge aclk);
      chk("rst_arready", bus.arready, 0);
      chk("rst_awready", bus.awready, 0);
      chk("rst_wready", bus.wready, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_bvalid", bus.bvalid, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_rresp", bus.rresp, 0);
      chk("rst_bresp", bus.bresp, 0);
      areset = 1'b1;
      #1 chk("rel_arready_before_edge", bus.arready, 0);
      @(negedge aclk);
      chk("rel_arready_after_edge", bus.arready, 1);
      chk("rel_awready_after_edge", bus.awready, 1);
      for (int w = 0; w < 32; w++) do_write(32'(w * 4), $urandom, 4'hF, 0);
      do_write(32'h10, 32'hDEADBEEF, 4'hF, 0);
      do_read(32'h10, 0);
      do_write(32'h20, 32'h11223344, 4'hF, 0);
      do_write(32'h20, 32'hAABBCCDD, 4'b0101, 0);
      chk("merge_model", model[8], 32'h11BB33DD);
      do_read(32'h20, 0);
      do_write(32'h40, 32'h5, 4'hF, 3);
      do_read(32'h40, 0);
      do_read(32'h1000, 0);
      do_write(32'h1000, 32'h12345678, 4'hF, 0);
      do_read(32'h10, 5);
      do_write(32'h24, 32'hFFFFFFFF, 4'h0, 0);
      do_read(32'h24, 0);
      old = model[5];
      d = ~old;
      bus.araddr  = 32'h14;
      bus.arvalid = 1'b1;
      @(negedge aclk);
      bus.arvalid = 1'b0;
      @(negedge aclk);
      chk("same_edge_ready", bus.awready && bus.wready, 1);
      bus.awaddr = 32'h14; bus.wdata = d; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(negedge aclk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      chk("same_edge_rvalid", bus.rvalid, 1);
      chk("same_edge_old_data", bus.rdata, old);
      model_write(32'h14, d, 4'hF);
      bus.rready = 1'b1;
      @(negedge aclk);
      bus.rready = 1'b0;
      chk("same_edge_bvalid", bus.bvalid, 1);
      bus.bready = 1'b1;
      @(negedge aclk);
      bus.bready = 1'b0;
      do_read(32'h14, 0);
      for (int k = 0; k < 40; k++) begin
         n = $urandom_range(0, 31);
         a = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'(n * 4) : 32'(n * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, $urandom_range(0, 4) - 2);
         end else
            do_read(a, $urandom_range(0, 3));
      end
      bus.araddr  = 32'h18;
      bus.arvalid = 1'b1;
      @(negedge aclk);
      bus.arvalid = 1'b0;
      bus.wdata  = ~model[6];
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      @(negedge aclk);
      bus.wvalid = 1'b0;
      chk("pre_rst_wready", bus.wready, 0);
      #2 areset = 1'b0;
      #1;
      chk("arst_arready", bus.arready, 0);
      chk("arst_awready", bus.awready, 0);
      chk("arst_wready", bus.wready, 0);
      chk("arst_rvalid", bus.rvalid, 0);
      chk("arst_bvalid", bus.bvalid, 0);
      chk("arst_rdata", bus.rdata, 0);
      chk("arst_rresp", bus.rresp, 0);
      chk("arst_bresp", bus.bresp, 0);
      repeat (2) @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      chk("post_rst_arready", bus.arready, 1);
      chk("post_rst_awready", bus.awready, 1);
      chk("post_rst_wready", bus.wready, 1);
      n = 0;
      repeat (8) begin
         @(negedge aclk);
         n += int'(bus.rvalid) + int'(bus.bvalid);
      end
      chk("post_rst_no_resp", n, 0);
      do_read(32'h18, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
